// File: rtl/bus_arbiter16.sv
// -----------------------------------------------------------------------------
// bus_arbiter16
//
// Round-robin arbiter for 16 requesters. The arbiter has one owner at a time.
// An owner holds the bus for at most MAX_HOLD consecutive cycles. Between two
// owners there is always exactly one dead cycle, in which gnt is all-zero.
// After an owner leaves, the search pointer moves to the index just past that
// owner. This gives the previous owner the lowest priority in the next search.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per owner (1..255)
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous active-high reset
//   req      in  16   bus request, bit i = requester i
//   gnt      out 16   registered one-hot grant, zero when the bus is free
//   gnt_id   out  4   registered index of the current (or last) owner
//   busy     out  1   registered, high exactly when gnt is nonzero
//   preempt  out  1   registered one-cycle pulse when the hold limit revokes
//                     a grant
// -----------------------------------------------------------------------------
module bus_arbiter16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        busy,
    output logic        preempt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  ptr_r;
    logic [3:0]  ptr_s;
    logic [7:0]  hold_r;
    logic [7:0]  hold_s;
    logic [15:0] gnt_s;
    logic [3:0]  gnt_id_s;
    logic        busy_s;
    logic        preempt_s;
    logic [4:0]  win_s;
    logic [8:0]  held_s;

    // Returns {found, index}. The search starts at ptr and moves upward with
    // wrap-around. The loop runs from the farthest offset down to the nearest,
    // so the nearest set bit is written last and wins.
    function automatic logic [4:0] find_winner(input logic [15:0] r,
                                               input logic [3:0]  p);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = p + 4'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, next-pointer, hold counter and next registered outputs.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        hold_s    = hold_r;
        gnt_s     = gnt;
        gnt_id_s  = gnt_id;
        busy_s    = busy;
        preempt_s = 1'b0;
        win_s     = find_winner(req, ptr_r);
        // Number of grant cycles that have elapsed, counting the current one.
        held_s    = {1'b0, hold_r} + 9'd1;

        case (state_r)
            ST_IDLE, ST_TURN: begin
                if (win_s[4]) begin
                    state_s  = ST_GRANT;
                    gnt_s    = 16'd1 << win_s[3:0];
                    gnt_id_s = win_s[3:0];
                    busy_s   = 1'b1;
                    hold_s   = 8'd0;
                end else begin
                    state_s  = ST_IDLE;
                    gnt_s    = 16'h0000;
                    busy_s   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id]) begin
                    // A release takes priority over a hold limit on the same edge.
                    state_s  = ST_TURN;
                    gnt_s    = 16'h0000;
                    busy_s   = 1'b0;
                    ptr_s    = gnt_id + 4'd1;
                end else if (held_s >= 9'(MAX_HOLD)) begin
                    state_s   = ST_TURN;
                    gnt_s     = 16'h0000;
                    busy_s    = 1'b0;
                    preempt_s = 1'b1;
                    ptr_s     = gnt_id + 4'd1;
                end else begin
                    hold_s   = held_s[7:0];
                end
            end
            default: begin
                state_s  = ST_IDLE;
                gnt_s    = 16'h0000;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and registered outputs. The synchronous reset overrides any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= 4'd0;
            hold_r  <= 8'd0;
            gnt     <= 16'h0000;
            gnt_id  <= 4'd0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            hold_r  <= hold_s;
            gnt     <= gnt_s;
            gnt_id  <= gnt_id_s;
            busy    <= busy_s;
            preempt <= preempt_s;
        end
    end

endmodule

// File: tb/tb_bus_arbiter16.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter16
//
// Self-checking bench for bus_arbiter16. It drives two instances: one with
// MAX_HOLD=8 and one with MAX_HOLD=1. A behavioural model tracks the owner,
// the number of cycles that owner has held the bus, and the search start
// position. The model does not separate IDLE from TURN, because both states
// arbitrate in the same way. It predicts every output on every cycle.
// Directed scenarios come first, then randomized traffic with occasional
// resets.
// -----------------------------------------------------------------------------
module tb_bus_arbiter16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] req1;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        busy;
    logic        preempt;
    logic [15:0] gnt1;
    logic [3:0]  gnt_id1;
    logic        busy1;
    logic        preempt1;

    int n_tests;
    int n_fail;

    // model state, index 0 = MAX_HOLD 8 instance, index 1 = MAX_HOLD 1 instance
    int          m_owner [2];
    int          m_held  [2];
    int          m_start [2];
    logic [15:0] m_gnt   [2];
    logic [3:0]  m_id    [2];
    logic        m_busy  [2];
    logic        m_pre   [2];

    bus_arbiter16 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .preempt(preempt)
    );

    bus_arbiter16 #(.MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst(rst), .req(req1),
        .gnt(gnt1), .gnt_id(gnt_id1), .busy(busy1), .preempt(preempt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model step for one edge, using the inputs sampled at that edge.
    task automatic model_step(input int k, input logic r_rst, input logic [15:0] r, input int maxh);
        m_pre[k] = 1'b0;
        if (r_rst) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_start[k] = 0;
            m_id[k]    = 4'd0;
        end else if (m_owner[k] >= 0) begin
            if (!r[m_owner[k]]) begin
                m_start[k] = (m_owner[k] + 1) % 16;
                m_owner[k] = -1;
            end else if (m_held[k] >= maxh) begin
                m_pre[k]   = 1'b1;
                m_start[k] = (m_owner[k] + 1) % 16;
                m_owner[k] = -1;
            end else begin
                m_held[k] = m_held[k] + 1;
            end
        end else begin
            for (int j = 0; j < 16; j++) begin
                int c;
                c = (m_start[k] + j) % 16;
                if (r[c]) begin
                    m_owner[k] = c;
                    m_held[k]  = 1;
                    m_id[k]    = c[3:0];
                    break;
                end
            end
        end
        m_gnt[k]  = (m_owner[k] >= 0) ? (16'd1 << m_owner[k]) : 16'h0000;
        m_busy[k] = (m_owner[k] >= 0);
    endtask

    // Advance one clock and compare both instances against the model.
    task automatic tick();
        model_step(0, rst, req, 8);
        model_step(1, rst, req1, 1);
        @(posedge clk);
        #1;
        check_eq("gnt",      32'(gnt),      32'(m_gnt[0]));
        check_eq("gnt_id",   32'(gnt_id),   32'(m_id[0]));
        check_eq("busy",     32'(busy),     32'(m_busy[0]));
        check_eq("preempt",  32'(preempt),  32'(m_pre[0]));
        check_eq("gnt_h1",   32'(gnt1),     32'(m_gnt[1]));
        check_eq("gnt_id_h1", 32'(gnt_id1), 32'(m_id[1]));
        check_eq("busy_h1",  32'(busy1),    32'(m_busy[1]));
        check_eq("preempt_h1", 32'(preempt1), 32'(m_pre[1]));
        check_eq("onehot",   32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        req  = 16'h0000;
        req1 = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_held[k] = 0; m_start[k] = 0;
            m_gnt[k] = 16'h0; m_id[k] = 4'd0; m_busy[k] = 1'b0; m_pre[k] = 1'b0;
        end

        // reset state, with requests present that must be ignored
        req  = 16'hFFFF;
        req1 = 16'hFFFF;
        tick();
        tick();
        check_eq("rst_gnt",  32'(gnt), 32'h0);
        check_eq("rst_id",   32'(gnt_id), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_pre",  32'(preempt), 32'h0);
        req  = 16'h0000;
        req1 = 16'h0000;
        do_reset();

        // single requester: grant one edge after req, release after drop
        req = 16'h0001;
        tick();
        check_eq("s_gnt", 32'(gnt), 32'h1);
        check_eq("s_id",  32'(gnt_id), 32'h0);
        tick();
        tick();
        req = 16'h0000;
        tick();
        check_eq("s_drop", 32'(gnt), 32'h0);
        check_eq("s_drop_pre", 32'(preempt), 32'h0);
        tick();
        check_eq("s_idle", 32'(busy), 32'h0);

        // all requesting: owners 0..15 then 0, each 8 cycles, preempt per handover
        do_reset();
        req = 16'hFFFF;
        for (int o = 0; o < 17; o++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                check_eq("rr_gnt", 32'(gnt), 32'h1 << (o % 16));
                check_eq("rr_id",  32'(gnt_id), 32'(o % 16));
            end
            if (o < 16) begin
                tick();
                check_eq("rr_dead", 32'(gnt), 32'h0);
                check_eq("rr_pre",  32'(preempt), 32'h1);
            end
        end

        // owner 15 releases: the search wraps to 0, ahead of requester 14
        do_reset();
        req = 16'h8000;
        tick();
        check_eq("w_own15", 32'(gnt_id), 32'd15);
        req = 16'h8001;
        tick();
        check_eq("w_hold15", 32'(gnt), 32'h8000);
        req = 16'h4001;
        tick();
        check_eq("w_dead", 32'(gnt), 32'h0);
        tick();
        check_eq("w_wrap", 32'(gnt), 32'h0001);
        req = 16'h0000;
        tick();
        tick();

        // owner 3 drops its request on the hold-limit edge: release, no preempt
        do_reset();
        req = 16'h0018;
        tick();
        check_eq("h_own3", 32'(gnt), 32'h0008);
        for (int c = 0; c < 7; c++) tick();
        check_eq("h_still3", 32'(gnt), 32'h0008);
        req = 16'h0010;
        tick();
        check_eq("h_dead", 32'(gnt), 32'h0);
        check_eq("h_nopre", 32'(preempt), 32'h0);
        tick();
        check_eq("h_next4", 32'(gnt), 32'h0010);
        req = 16'h0000;
        tick();
        tick();

        // reset while owner 5 holds: gnt drops at once, then search starts at 0
        do_reset();
        req = 16'h0020;
        tick();
        req = 16'h0021;
        tick();
        check_eq("r_own5", 32'(gnt), 32'h0020);
        rst = 1'b1;
        tick();
        check_eq("r_drop", 32'(gnt), 32'h0);
        check_eq("r_id0",  32'(gnt_id), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("r_next0", 32'(gnt), 32'h0001);
        req = 16'h0000;

        // MAX_HOLD=1 instance alternates between requesters 1 and 2
        do_reset();
        req1 = 16'h0006;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("m1_gnt2", 32'(gnt1), 32'h0002);
            tick();
            check_eq("m1_dead", 32'(gnt1), 32'h0);
            check_eq("m1_pre",  32'(preempt1), 32'h1);
            tick();
            check_eq("m1_gnt4", 32'(gnt1), 32'h0004);
            tick();
            check_eq("m1_dead2", 32'(gnt1), 32'h0);
            check_eq("m1_pre2",  32'(preempt1), 32'h1);
        end

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req  = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) req1 = 16'($urandom);
            rst = ($urandom_range(0, 150) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
